// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared Manchester line constants and receiver state type
// Purpose: state encoding, oversample ratio, sample phases and resync window
//          shared by the Manchester receiver and transmitter.
// Ports:   none (package).
package manchester_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ARMED = 2'd1,
        RECV  = 2'd2
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int PHASE_W    = $clog2(OVERSAMPLE);

    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [PHASE_W-1:0] PHASE_H1     = PHASE_W'(4);
    localparam logic [PHASE_W-1:0] PHASE_H2     = PHASE_W'(12);
    localparam logic [PHASE_W-1:0] RESYNC_LO    = PHASE_W'(6);
    localparam logic [PHASE_W-1:0] RESYNC_HI    = PHASE_W'(10);
    localparam logic [PHASE_W-1:0] RESYNC_PHASE = PHASE_W'(8);

endpackage

// File: rtl/clkenb.sv
// rtl/clkenb.sv - clock-enable divider producing a one-clk pulse at DIVFREQ
// Purpose: divides clk (CLKFREQ Hz) down to a single-cycle enable at DIVFREQ Hz.
// Ports:   clk   - system clock
//          reset - asynchronous active-high reset
//          enb   - one-clk enable pulse every CLKFREQ/DIVFREQ cycles
module clkenb #(
    parameter int CLKFREQ = 100_000_000,
    parameter int DIVFREQ = 153_600
) (
    input  logic clk,
    input  logic reset,
    output logic enb
);

    localparam int DIV = (CLKFREQ / DIVFREQ < 1) ? 1 : CLKFREQ / DIVFREQ;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            enb   <= 1'b0;
        end else if (count == W'(DIV - 1)) begin
            count <= '0;
            enb   <= 1'b1;
        end else begin
            count <= count + W'(1);
            enb   <= 1'b0;
        end
    end

endmodule

// File: rtl/manchester_receiver.sv
// rtl/manchester_receiver.sv - Manchester-coded serial byte receiver with carrier detect
// Purpose: recovers LSB-first bytes from a Manchester line (first half = ~bit,
//          second half = bit), 16x oversampled, framed by idle-high line.
// Ports:   clk    - system clock (rising edge)
//          rst    - asynchronous active-low reset
//          rxd    - serial line, idle high, asynchronous to clk
//          data   - last complete byte, held until the next one completes
//          valid  - one-clk pulse when data updates
//          cardet - high while a frame is being received
//          error  - one-clk pulse on coding violation or truncated byte
// Build option: define MANCHESTER_RX_RESYNC_EN to re-centre the bit phase on
//          each mid-bit edge (tracks transmitter baud drift).
module manchester_receiver
    import manchester_pkg::*;
#(
    parameter int BAUD    = 9600,
    parameter int CLKFREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       cardet,
    output logic       error
);

    logic tick;
    logic tick_reset;

    logic rxd_meta;
    logic rxd_s;
    logic rxd_prev;
    logic fall;

    rx_state_t          state, state_n;
    logic [PHASE_W-1:0] idle_cnt, idle_n;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [2:0]         bit_idx, bit_n;
    logic [7:0]         shreg, shreg_n;
    logic               h1, h1_n;
    logic [7:0]         data_n;
    logic               valid_n;
    logic               cardet_n;
    logic               error_n;

`ifdef MANCHESTER_RX_RESYNC_EN
    logic resync_pend, resync_n;
    logic rxd_edge;
`endif

    assign tick_reset = ~rst;

    clkenb #(
        .CLKFREQ (CLKFREQ),
        .DIVFREQ (BAUD * OVERSAMPLE)
    ) u_clkenb (
        .clk   (clk),
        .reset (tick_reset),
        .enb   (tick)
    );

    // Synchronizer resets to the idle level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    assign fall = rxd_prev & ~rxd_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            idle_cnt    <= '0;
            phase       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            h1          <= 1'b0;
            data        <= 8'h00;
            valid       <= 1'b0;
            cardet      <= 1'b0;
            error       <= 1'b0;
`ifdef MANCHESTER_RX_RESYNC_EN
            resync_pend <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            idle_cnt    <= idle_n;
            phase       <= phase_n;
            bit_idx     <= bit_n;
            shreg       <= shreg_n;
            h1          <= h1_n;
            data        <= data_n;
            valid       <= valid_n;
            cardet      <= cardet_n;
            error       <= error_n;
`ifdef MANCHESTER_RX_RESYNC_EN
            resync_pend <= resync_n;
`endif
        end
    end

`ifdef MANCHESTER_RX_RESYNC_EN
    assign rxd_edge = rxd_prev ^ rxd_s;
`endif

    always_comb begin
        state_n  = state;
        idle_n   = idle_cnt;
        phase_n  = phase;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        h1_n     = h1;
        data_n   = data;
        valid_n  = 1'b0;
        cardet_n = cardet;
        error_n  = 1'b0;
`ifdef MANCHESTER_RX_RESYNC_EN
        resync_n = resync_pend;
`endif

        case (state)
            HUNT: begin
                cardet_n = 1'b0;
                if (!rxd_s) begin
                    idle_n = '0;
                end else if (tick) begin
                    if (idle_cnt == PHASE_LAST) begin
                        idle_n  = '0;
                        state_n = ARMED;
                    end else begin
                        idle_n = idle_cnt + PHASE_W'(1);
                    end
                end
            end

            ARMED: begin
                // The first falling edge marks the start of bit 0 (LSB must be 1).
                if (fall) begin
                    phase_n  = '0;
                    bit_n    = '0;
                    cardet_n = 1'b1;
                    state_n  = RECV;
`ifdef MANCHESTER_RX_RESYNC_EN
                    resync_n = 1'b0;
`endif
                end
            end

            RECV: begin
`ifdef MANCHESTER_RX_RESYNC_EN
                // Mid-bit transitions land near phase 8; latch and snap on the next tick.
                if (rxd_edge && (phase >= RESYNC_LO) && (phase <= RESYNC_HI))
                    resync_n = 1'b1;
`endif
                if (tick) begin
                    phase_n = phase + PHASE_W'(1);
`ifdef MANCHESTER_RX_RESYNC_EN
                    if (resync_pend) begin
                        phase_n  = RESYNC_PHASE;
                        resync_n = 1'b0;
                    end
`endif
                    if (phase == PHASE_H1)
                        h1_n = rxd_s;

                    if (phase == PHASE_H2) begin
                        if (h1 != rxd_s) begin
                            shreg_n = {rxd_s, shreg[7:1]};
                            bit_n   = bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                data_n  = {rxd_s, shreg[7:1]};
                                valid_n = 1'b1;
                            end
                        end else if (rxd_s && (bit_idx == 3'd0)) begin
                            // Idle-high bit slot on a byte boundary: clean end of frame.
                            cardet_n = 1'b0;
                            idle_n   = '0;
                            state_n  = HUNT;
                        end else begin
                            error_n  = 1'b1;
                            cardet_n = 1'b0;
                            shreg_n  = '0;
                            bit_n    = '0;
                            idle_n   = '0;
                            state_n  = HUNT;
                        end
                    end
                end
            end

            default: begin
                state_n  = HUNT;
                cardet_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_manchester_receiver.sv
// tb/tb_manchester_receiver.sv - self-checking bench for manchester_receiver
module tb_manchester_receiver;

    localparam int HALF       = 80;
    localparam int HALF_FAST  = 77;
    localparam int IDLE_CLKS  = 320;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       cardet;
    logic       error;

    always #5 clk = ~clk;

    manchester_receiver #(
        .BAUD    (625_000),
        .CLKFREQ (100_000_000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .data   (data),
        .valid  (valid),
        .cardet (cardet),
        .error  (error)
    );

    int         tests = 0;
    int         failed = 0;

    int         nvalid = 0;
    int         nerr = 0;
    int         nboth = 0;
    int         ncardet = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (valid) begin
            nvalid++;
            rxq.push_back(data);
        end
        if (error) nerr++;
        if (valid && error) nboth++;
        if (cardet) ncardet++;
    end

    typedef struct {
        int              nbytes;
        logic [3:0][7:0] bytes;
        int              last_bits;
        int              tail;
        int              exp_valid;
        int              exp_err;
        logic [7:0]      exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int half);
        rxd = ~b;
        repeat (half) @(negedge clk);
        rxd = b;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) send_bit(v[i], half);
    endtask

    function automatic logic [7:0] drift_byte(input int i);
        logic [7:0] v;
        v = 8'(i * 29 + 3);
        return (i == 0) ? 8'h55 : v;
    endfunction

    initial begin
        int         bv, be, bc, bq, got, nb;
        logic [7:0] exp_b;
        bit         ok;

        vecs[0] = '{2, 32'h0000_A755, 8, 0, 2, 0, 8'hA7};
        vecs[1] = '{1, 32'h0000_0055, 8, 1, 1, 1, 8'h55};
        vecs[2] = '{2, 32'h0000_A755, 4, 0, 1, 1, 8'h55};
        vecs[3] = '{3, 32'h00FF_0055, 8, 0, 3, 0, 8'hFF};
        vecs[4] = '{4, 32'hC37E_8155, 8, 0, 4, 0, 8'hC3};

        rst = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data",   int'(data),   0);
        check("reset_valid",  int'(valid),  0);
        check("reset_cardet", int'(cardet), 0);
        check("reset_error",  int'(error),  0);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            idle(IDLE_CLKS);
            bv = nvalid; be = nerr; bc = ncardet; bq = rxq.size();
            for (int b = 0; b < vecs[k].nbytes; b++)
                send_byte(vecs[k].bytes[b], (b == vecs[k].nbytes - 1) ? vecs[k].last_bits : 8, HALF);
            if (vecs[k].tail == 1) begin
                rxd = 1'b0;
                repeat (6 * HALF) @(negedge clk);
            end
            idle(4 * HALF);
            check($sformatf("v%0d_valid_count", k), nvalid - bv, vecs[k].exp_valid);
            check($sformatf("v%0d_error_count", k), nerr - be, vecs[k].exp_err);
            check($sformatf("v%0d_data", k), int'(data), int'(vecs[k].exp_data));
            check($sformatf("v%0d_cardet_end", k), int'(cardet), 0);
            check($sformatf("v%0d_cardet_seen", k), int'(ncardet > bc), 1);
            for (int i = 0; i < vecs[k].exp_valid; i++) begin
                got = (bq + i < rxq.size()) ? int'(rxq[bq + i]) : -1;
                check($sformatf("v%0d_byte%0d", k, i), got, int'(vecs[k].bytes[i]));
            end
        end

        // Reset mid-byte: outputs clear at once, no error pulse, re-hunt required.
        idle(IDLE_CLKS);
        bv = nvalid; be = nerr; bq = rxq.size();
        send_byte(8'h55, 5, HALF);
        rxd = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_data",   int'(data),   0);
        check("midrst_valid",  int'(valid),  0);
        check("midrst_cardet", int'(cardet), 0);
        check("midrst_error",  int'(error),  0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bc = ncardet;
        idle(100);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        check("early_edge_cardet", ncardet - bc, 0);

        // One-clk low glitch in HUNT must restart the idle count.
        idle(130);
        rxd = 1'b0;
        @(negedge clk);
        idle(100);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_cardet", ncardet - bc, 0);
        check("glitch_valid",  nvalid - bv, 0);

        idle(IDLE_CLKS);
        send_byte(8'h55, 8, HALF);
        send_byte(8'h3C, 8, HALF);
        idle(4 * HALF);
        check("postrst_valid_count", nvalid - bv, 2);
        check("postrst_error_count", nerr - be, 0);
        check("postrst_data", int'(data), 8'h3C);
        got = (bq < rxq.size()) ? int'(rxq[bq]) : -1;
        check("postrst_byte0", got, 8'h55);
        got = (bq + 1 < rxq.size()) ? int'(rxq[bq + 1]) : -1;
        check("postrst_byte1", got, 8'h3C);

        // Transmitter running fast (77-clk halves against nominal 80).
        idle(IDLE_CLKS);
        bv = nvalid; be = nerr; bq = rxq.size();
        for (int i = 0; i < 16; i++) send_byte(drift_byte(i), 8, HALF_FAST);
        idle(4 * HALF);
        nb = nvalid - bv;
        ok = (nerr == be) && (nb == 16);
        for (int i = 0; i < 16; i++) begin
            exp_b = drift_byte(i);
            if (bq + i >= rxq.size()) ok = 1'b0;
            else if (rxq[bq + i] != exp_b) ok = 1'b0;
        end
`ifdef MANCHESTER_RX_RESYNC_EN
        check("drift_all_bytes_ok", int'(ok), 1);
`else
        check("drift_breaks_without_resync", int'(ok), 0);
`endif

        check("valid_error_overlap", nboth, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/manchester_receiver.md
MANCHESTER_RECEIVER -- requirements
Module: manchester_receiver

Interface
REQ-001 SHALL have parameter BAUD, default 9600, meaning the line bit rate in bits/s.
REQ-002 SHALL have parameter CLKFREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port rxd  input  1  meaning the Manchester serial line, idle high and asynchronous to clk.
REQ-006 SHALL have port data  output  8  meaning the last received byte, held until the next byte completes.
REQ-007 SHALL have port valid  output  1  meaning a one-clk pulse that data has just been updated.
REQ-008 SHALL have port cardet  output  1  meaning carrier detect, high while a frame is being received.
REQ-009 SHALL have port error  output  1  meaning a one-clk pulse on a coding violation or truncated byte.

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer before any use; all latencies below exclude these 2 cycles.
REQ-011 SHALL derive a sample tick at 16x BAUD; phase counter 0..15 counts ticks within one bit.
REQ-012 SHALL use line coding per bit as follows: first half is the complement of the bit, second half is the bit, bits are sent LSB first, and there is no start or stop bit.
REQ-013 SHALL implement states HUNT, ARMED, RECV.
REQ-014 In HUNT, the block SHALL move to ARMED after the synchronized rxd has been high for 16 consecutive ticks, and any low SHALL restart the count.
REQ-015 In ARMED, a falling edge SHALL set phase=0, bit index=0, cardet=1, and move to RECV; the first byte of every frame therefore has LSB=1 (team preamble 0x55).
REQ-016 In RECV, the block SHALL sample h1 at phase 4 and h2 at phase 12; if h1!=h2, it SHALL shift h2 into the shift register at the MSB with a right shift, and increment the bit index.
REQ-017 After the 8th bit, the block SHALL load data, pulse valid for exactly one clk in the cycle after the phase-12 sample, reset the bit index to 0, and stay in RECV.
REQ-018 If h1==h2==1 at bit index 0, the block SHALL treat it as end of frame: cardet=0, no error, and go to HUNT.
REQ-019 If h1==h2 at bit index 1..7, or h1==h2==0 at any index, the block SHALL pulse error, discard the partial byte, set cardet=0, and go to HUNT.
REQ-020 The phase counter SHALL wrap 15->0; a wrap SHALL start the next bit.
REQ-021 valid and error SHALL never be asserted in the same cycle.
REQ-022 data SHALL be unchanged by error, end of frame, or reset release.

Reset
REQ-023 When rst=0, the block SHALL asynchronously set the state to HUNT, set data=0x00, valid=0, cardet=0, error=0, and clear the phase, bit index, shift register, synchronizer (to 1), and the tick divider.
REQ-024 A reset mid-frame SHALL abandon the frame without an error pulse, and the block SHALL require 16 idle-high ticks after release before arming.

Configuration
REQ-025 With macro MANCHESTER_RX_RESYNC_EN defined, any rxd edge seen in RECV at phase 6..10 SHALL force phase=8 on the next tick to track baud drift.
REQ-026 Without MANCHESTER_RX_RESYNC_EN, the phase SHALL free-run from the ARMED edge, and the block SHALL tolerate at most ±2% baud mismatch over 8 bytes.

Structure
REQ-027 The state enum (HUNT, ARMED, RECV), the oversample constant 16, and the sample phases 4/12 and resync window 6..10 SHALL reside in the shared package manchester_pkg, which the transmitter side also imports.
REQ-028 The tick SHALL come from one instance of the existing clkenb sub-module with DIVFREQ=BAUD*16, with its reset tied to the inverted rst.

Verification (CLKFREQ=100_000_000, BAUD=625_000, giving 10 clk per tick)
REQ-029 The bench SHALL cover: idle high 2 bit times, then frame 0x55,0xA7, then idle -> valid twice with data=0x55 then 0xA7, cardet falls after the idle bit, and error never asserts.
REQ-030 The bench SHALL cover: frame 0x55, then rxd held low 3 bit times -> valid with 0x55, then one error pulse, cardet=0, and the state returns to HUNT.
REQ-031 The bench SHALL cover: frame 0x55 with the line forced high after bit 3 of the second byte -> one error pulse, and data remains 0x55.
REQ-032 The bench SHALL cover: rst asserted at bit 5 of the byte 0x55 -> all outputs 0 immediately with no error pulse; after release, 0x55,0x3C is received correctly only after 16 idle ticks.
REQ-033 The bench SHALL cover: with MANCHESTER_RX_RESYNC_EN defined and the transmitter 4% fast, 16 bytes -> all received correctly; without the macro, the same stimulus produces at least one error or wrong byte.
REQ-034 The bench SHALL cover: a glitch of 1 clk low on an idle line in HUNT -> no transition to RECV, and cardet stays 0.
